// File: rtl/onchip_mem_stream_reader.sv
// Avalon-MM read master: streams LENGTH consecutive RAM words from BASE_ADDR with sop/eop, wrapping at MEM_DEPTH.
// First beat 2 cycles after first read; reads throttle so FIFO plus in-flight never exceeds FIFO_DEPTH under st_ready backpressure.

module onchip_mem_stream_reader_fifo #(
  parameter int W     = 34,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic [W-1:0]           push_dat,
  input  logic                   pop,
  output logic [W-1:0]           head_dat,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign do_pop   = pop && !empty;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign do_push  = push && (!full || do_pop);
  assign head_dat = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end
endmodule

module onchip_mem_stream_reader #(
  parameter int ADDR_W     = 17,
  parameter int DATA_W     = 32,
  parameter int MEM_DEPTH  = 102400,
  parameter int LEN_W      = 18,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [3:0]        mem_byteenable,
  output logic              mem_clken,
  input  logic [DATA_W-1:0] mem_readdata,
  output logic [DATA_W-1:0] st_data,
  output logic              st_valid,
  input  logic              st_ready,
  output logic              st_sop,
  output logic              st_eop
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  state_t            state;
  state_t            state_nxt;
  logic [LEN_W-1:0]  len_q;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  capt_idx;
  logic              inflight;
  logic              issue;
  logic              accept;
  logic              pop;
  logic              fifo_empty;
  logic [CW-1:0]     fifo_count;
  logic [DATA_W+1:0] push_dat;
  logic [DATA_W+1:0] head_dat;

  assign accept = (state == S_IDLE) && start;
  assign issue  = (state == S_FETCH) && (issued != len_q) &&
                  ((fifo_count + CW'(inflight)) < CW'(FIFO_DEPTH));
  assign pop    = st_valid && st_ready;

  // Beat tags travel with the data so sop/eop stay aligned under backpressure.
  assign push_dat = {(capt_idx == '0), (capt_idx == len_q - LEN_W'(1)), mem_readdata};

  onchip_mem_stream_reader_fifo #(
    .W     (DATA_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (inflight),
    .push_dat (push_dat),
    .pop      (pop),
    .head_dat (head_dat),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      len_q       <= '0;
      issued      <= '0;
      capt_idx    <= '0;
      inflight    <= 1'b0;
      mem_address <= '0;
    end else begin
      state    <= state_nxt;
      inflight <= issue;
      if (accept) begin
        len_q       <= length;
        issued      <= '0;
        capt_idx    <= '0;
        mem_address <= base_addr;
      end else begin
        if (issue) begin
          issued      <= issued + LEN_W'(1);
          mem_address <= (mem_address == ADDR_W'(MEM_DEPTH - 1)) ? '0 : mem_address + ADDR_W'(1);
        end
        if (inflight) capt_idx <= capt_idx + LEN_W'(1);
      end
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start) state_nxt = (length == '0) ? S_DONE : S_FETCH;
      S_FETCH: if (issued == len_q) state_nxt = S_DRAIN;
      S_DRAIN: if (pop && head_dat[DATA_W]) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  assign busy           = (state == S_FETCH) || (state == S_DRAIN);
  assign done           = (state == S_DONE);
  assign mem_chipselect = issue;
  assign mem_write      = 1'b0;
  assign mem_byteenable = 4'hF;
  assign mem_clken      = 1'b1;
  assign st_valid       = !fifo_empty;
  assign st_data        = head_dat[DATA_W-1:0];
  assign st_sop         = st_valid && head_dat[DATA_W+1];
  assign st_eop         = st_valid && head_dat[DATA_W];
endmodule

// File: tb/tb_onchip_mem_stream_reader.sv
// Bench for onchip_mem_stream_reader: RAM model, vector table, random commands and hand-written corner sequences.
module tb_onchip_mem_stream_reader;
  localparam int MEM_DEPTH = 102400;

  logic        clk;
  logic        reset;
  logic        start;
  logic [16:0] base_addr;
  logic [17:0] length;
  logic        busy;
  logic        done;
  logic [16:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [3:0]  mem_byteenable;
  logic        mem_clken;
  logic [31:0] mem_readdata;
  logic [31:0] st_data;
  logic        st_valid;
  logic        st_ready;
  logic        st_sop;
  logic        st_eop;

  logic [31:0] ram [MEM_DEPTH];
  int n_cmp;
  int n_err;

  typedef struct {
    int base;
    int len;
    int rmode;
    bit repulse;
    int exp_lat;
  } vec_t;
  vec_t vt[8];

  onchip_mem_stream_reader dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .length         (length),
    .busy           (busy),
    .done           (done),
    .mem_address    (mem_address),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_byteenable (mem_byteenable),
    .mem_clken      (mem_clken),
    .mem_readdata   (mem_readdata),
    .st_data        (st_data),
    .st_valid       (st_valid),
    .st_ready       (st_ready),
    .st_sop         (st_sop),
    .st_eop         (st_eop)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_chipselect) mem_readdata <= ram[mem_address];
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_cs"}, mem_chipselect, 0);
    chk({tag, "_addr"}, mem_address, 0);
    chk({tag, "_valid"}, st_valid, 0);
    chk({tag, "_sop"}, st_sop, 0);
    chk({tag, "_eop"}, st_eop, 0);
  endtask

  // Reference: word i of a command is ram[(base+i) mod MEM_DEPTH]; at most 4 words outstanding.
  task automatic run_cmd(input int base, input int len, input int rmode, input bit repulse, input int exp_lat);
    int iss, got, cyc, first_v, eop_c, done_c, occ, idx;
    logic stalled, ps, pe;
    logic [31:0] pd;
    iss = 0; got = 0; cyc = 0; first_v = -1; eop_c = -1; done_c = -1;
    stalled = 0; pd = 0; ps = 0; pe = 0;
    start = 1; base_addr = 17'(base); length = 18'(len);
    step();
    start = 0;
    chk("busy_after_start", busy, (len != 0));
    while (done_c < 0 && cyc < 3000) begin
      occ = iss - got;
      if (busy && iss < len) chk("cs_rule", mem_chipselect, (occ < 4));
      else chk("cs_off", mem_chipselect, 0);
      if (mem_chipselect) begin
        chk("addr", mem_address, (base + iss) % MEM_DEPTH);
        iss++;
      end
      if (stalled) begin
        chk("hold_valid", st_valid, 1);
        chk("hold_data", st_data, pd);
        chk("hold_sop", st_sop, ps);
        chk("hold_eop", st_eop, pe);
      end
      case (rmode)
        0:       st_ready = 1;
        1:       st_ready = ($urandom_range(0, 99) < 55);
        default: st_ready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      endcase
      if (st_valid && first_v < 0) first_v = cyc;
      if (st_valid && st_ready) begin
        if (got < len) begin
          idx = (base + got) % MEM_DEPTH;
          chk("beat_data", st_data, ram[idx]);
          chk("beat_sop", st_sop, (got == 0));
          chk("beat_eop", st_eop, (got == len - 1));
        end else begin
          chk("extra_beat", st_valid, 0);
        end
        if (st_eop) eop_c = cyc;
        got++;
      end
      stalled = st_valid && !st_ready;
      pd = st_data; ps = st_sop; pe = st_eop;
      if (done) done_c = cyc;
      if (repulse && cyc == 3) begin
        start = 1;
        base_addr = 17'((base + 500) % MEM_DEPTH);
        length = 18'd7;
      end else begin
        start = 0;
      end
      step();
      cyc++;
    end
    chk("done_seen", (done_c >= 0), 1);
    chk("beat_count", got, len);
    chk("read_count", iss, len);
    if (len == 0) chk("done_lat_len0", done_c, 0);
    else chk("done_after_eop", done_c, eop_c + 1);
    if (exp_lat >= 0) begin
      chk("first_valid_lat", first_v, exp_lat);
      chk("throughput", eop_c - first_v, len - 1);
    end
    chk("done_one_cycle", done, 0);
    chk("busy_after_done", busy, 0);
  endtask

  initial begin
    int got, cyc, rm;
    n_cmp = 0; n_err = 0;
    clk = 0; reset = 1; start = 0; base_addr = 0; length = 0; st_ready = 0;
    for (int i = 0; i < MEM_DEPTH; i++) ram[i] = 32'(i);

    vt[0] = '{base: 16,     len: 8,  rmode: 0, repulse: 0, exp_lat: 2};
    vt[1] = '{base: 102398, len: 4,  rmode: 0, repulse: 0, exp_lat: 2};
    vt[2] = '{base: 40,     len: 16, rmode: 2, repulse: 0, exp_lat: -1};
    vt[3] = '{base: 0,      len: 0,  rmode: 0, repulse: 0, exp_lat: -1};
    vt[4] = '{base: 500,    len: 1,  rmode: 0, repulse: 0, exp_lat: 2};
    vt[5] = '{base: 102399, len: 3,  rmode: 1, repulse: 0, exp_lat: -1};
    vt[6] = '{base: 2000,   len: 12, rmode: 1, repulse: 1, exp_lat: -1};
    vt[7] = '{base: 7,      len: 16, rmode: 1, repulse: 0, exp_lat: -1};

    step(); step(); step();
    chk_reset_vals("reset");
    chk("mem_write", mem_write, 0);
    chk("mem_byteenable", mem_byteenable, 4'hF);
    chk("mem_clken", mem_clken, 1);
    reset = 0;
    step();

    foreach (vt[k]) run_cmd(vt[k].base, vt[k].len, vt[k].rmode, vt[k].repulse, vt[k].exp_lat);

    for (int k = 0; k < 12; k++) begin
      rm = $urandom_range(0, 2);
      run_cmd($urandom_range(0, MEM_DEPTH - 1), $urandom_range(1, 40), rm, 0, (rm == 0) ? 2 : -1);
    end

    // Abort a long command after five beats, then confirm a fresh short command is clean.
    start = 1; base_addr = 17'd300; length = 18'd32;
    step();
    start = 0; st_ready = 1;
    got = 0; cyc = 0;
    while (got < 5 && cyc < 100) begin
      if (st_valid && st_ready) begin
        chk("pre_reset_data", st_data, ram[300 + got]);
        got++;
      end
      step();
      cyc++;
    end
    chk("pre_reset_beats", got, 5);
    reset = 1; st_ready = 0;
    step();
    chk_reset_vals("mid_reset");
    reset = 0;
    step();
    chk("post_reset_valid", st_valid, 0);
    run_cmd(1000, 2, 0, 0, 2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
